// File: rtl/seven_segment_scan_decoder.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_decoder
//
// Watches the anode and segment lines of a multiplexed 4-digit, active-low
// seven-segment display and reconstructs the hex value being shown. Each
// digit activation must stay stable for SETTLE_CYCLES cycles before it is
// sampled. Once all four digits have been captured, the frame is published
// on result.
//
// Parameters
//   SETTLE_CYCLES : consecutive stable cycles needed before a digit is
//                   sampled (2..255)
//
// Ports
//   clk          : rising-edge system clock
//   rst          : asynchronous, active-high reset
//   anode1..4    : active-low digit selects; anodeN maps to result[4N-1:4N-4]
//   segment      : active-low segment pattern, bit order {g,f,e,d,c,b,a}
//   result       : last complete decoded 4-digit value
//   frame_valid  : one-cycle pulse when result updates
//   frame_err    : qualified by frame_valid; the frame held an invalid digit
//   pattern_err  : one-cycle pulse for each sampled invalid pattern
//   digit_seen   : per-anode capture mask of the frame in progress
// ---------------------------------------------------------------------------
module seven_segment_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        anode1,
  input  logic        anode2,
  input  logic        anode3,
  input  logic        anode4,
  input  logic [6:0]  segment,
  output logic [15:0] result,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        pattern_err,
  output logic [3:0]  digit_seen
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  // Registered pin copies (p0) and their one-cycle-older copies (p1).
  logic [3:0]  anode_p0;
  logic [6:0]  segment_p0;
  logic [3:0]  anode_p1;
  logic [6:0]  segment_p1;

  logic [7:0]  settle_cnt;
  logic [7:0]  settle_nxt;
  logic [3:0]  sel;
  logic        sel_valid;
  logic        changed;
  logic        sample;

  logic [4:0]  dec;
  logic        dec_ok;
  logic [3:0]  dec_nib;

  logic [15:0] staging;
  logic        err_flag;
  logic        frame_done;
  logic [3:0]  seen_nxt;
  logic        err_nxt;

  // Maps an active-low gfedcba pattern to {valid, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // ---- Stage p0/p1: input capture and change history ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_p0   <= 4'b1111;
      segment_p0 <= 7'h00;
      anode_p1   <= 4'b1111;
      segment_p1 <= 7'h00;
      settle_cnt <= 8'd0;
    end else begin
      anode_p0   <= {anode4, anode3, anode2, anode1};
      segment_p0 <= segment;
      anode_p1   <= anode_p0;
      segment_p1 <= segment_p0;
      settle_cnt <= settle_nxt;
    end
  end

  // ---- Settle tracking and sample decision on the p0 copies ----
  always_comb begin
    sel        = ~anode_p0;
    sel_valid  = $onehot(sel);
    changed    = (anode_p0 != anode_p1) || (segment_p0 != segment_p1);
    settle_nxt = settle_cnt;
    if (!sel_valid)
      settle_nxt = 8'd0;
    else if (changed)
      settle_nxt = 8'd1;
    else if (settle_cnt < SETTLE)
      settle_nxt = settle_cnt + 8'd1;
    // Fires only on the transition into SETTLE, so a long hold samples once.
    sample  = sel_valid && (settle_nxt == SETTLE) && (settle_cnt != SETTLE);
    dec     = seg_decode(segment_p0);
    dec_ok  = dec[4];
    dec_nib = dec[3:0];
  end

  // A completed mask is retired this cycle; a sample landing in the same
  // cycle starts the next frame from an empty mask.
  always_comb begin
    frame_done = (digit_seen == 4'b1111);
    seen_nxt   = frame_done ? 4'b0000 : digit_seen;
    err_nxt    = frame_done ? 1'b0 : err_flag;
    if (sample) begin
      seen_nxt = seen_nxt | sel;
      err_nxt  = err_nxt | ~dec_ok;
    end
  end

  // ---- Stage p2: staging, frame assembly and output pulses ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging     <= 16'h0000;
      digit_seen  <= 4'b0000;
      err_flag    <= 1'b0;
      result      <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      pattern_err <= 1'b0;
      if (frame_done) begin
        result      <= staging;
        frame_valid <= 1'b1;
        frame_err   <= err_flag;
      end
      if (sample) begin
        pattern_err <= ~dec_ok;
        // Invalid patterns leave the slot holding its previous digit.
        if (dec_ok) begin
          for (int i = 0; i < 4; i++) begin
            if (sel[i])
              staging[4*i +: 4] <= dec_nib;
          end
        end
      end
      digit_seen <= seen_nxt;
      err_flag   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
module tb_seven_segment_scan_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] result;
  logic        frame_valid;
  logic        frame_err;
  logic        pattern_err;
  logic [3:0]  digit_seen;

  int n_vec;
  int n_bad;
  int fv_cnt;
  int pe_cnt;
  int stray;
  logic ferr_last;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    int          fv;
    int          pe;
    logic        ferr;
    logic [15:0] res;
    logic [3:0]  seen;
  } vec_t;

  vec_t tbl [18];

  seven_segment_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .anode1      (an[0]),
    .anode2      (an[1]),
    .anode3      (an[2]),
    .anode4      (an[3]),
    .segment     (seg),
    .result      (result),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .pattern_err (pattern_err),
    .digit_seen  (digit_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (frame_valid) begin
      fv_cnt    = fv_cnt + 1;
      ferr_last = frame_err;
    end
    if (pattern_err) pe_cnt = pe_cnt + 1;
    if (frame_err && !frame_valid) stray = stray + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives the inputs and waits hold cycles.
  task automatic run_step(input logic [3:0] a, input logic [6:0] s, input int hold);
    an        = a;
    seg       = s;
    fv_cnt    = 0;
    pe_cnt    = 0;
    ferr_last = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; fv_cnt = 0; pe_cnt = 0; stray = 0; ferr_last = 1'b0;

    // Scan 4321
    tbl[0]  = '{4'b1110, 7'h79, 8, 0, 0, 1'b0, 16'h0000, 4'b0001};
    tbl[1]  = '{4'b1101, 7'h24, 8, 0, 0, 1'b0, 16'h0000, 4'b0011};
    tbl[2]  = '{4'b1011, 7'h30, 8, 0, 0, 1'b0, 16'h0000, 4'b0111};
    tbl[3]  = '{4'b0111, 7'h19, 8, 1, 0, 1'b0, 16'h4321, 4'b0000};
    tbl[4]  = '{4'b1111, 7'h7F, 4, 0, 0, 1'b0, 16'h4321, 4'b0000};
    // Short glitch on anode2, then idle
    tbl[5]  = '{4'b1101, 7'h24, 2, 0, 0, 1'b0, 16'h4321, 4'b0000};
    tbl[6]  = '{4'b1111, 7'h7F, 6, 0, 0, 1'b0, 16'h4321, 4'b0000};
    // Digits 0,8,invalid,F
    tbl[7]  = '{4'b1110, 7'h40, 8, 0, 0, 1'b0, 16'h4321, 4'b0001};
    tbl[8]  = '{4'b1101, 7'h00, 8, 0, 0, 1'b0, 16'h4321, 4'b0011};
    tbl[9]  = '{4'b1011, 7'h36, 8, 0, 1, 1'b0, 16'h4321, 4'b0111};
    tbl[10] = '{4'b0111, 7'h0E, 8, 1, 0, 1'b1, 16'hF380, 4'b0000};
    tbl[11] = '{4'b1111, 7'h7F, 4, 0, 0, 1'b0, 16'hF380, 4'b0000};
    // Re-capture of anode1 overwrites its slot without growing the mask
    tbl[12] = '{4'b1110, 7'h40, 8, 0, 0, 1'b0, 16'hF380, 4'b0001};
    tbl[13] = '{4'b1110, 7'h79, 8, 0, 0, 1'b0, 16'hF380, 4'b0001};
    tbl[14] = '{4'b1101, 7'h24, 8, 0, 0, 1'b0, 16'hF380, 4'b0011};
    tbl[15] = '{4'b1011, 7'h30, 8, 0, 0, 1'b0, 16'hF380, 4'b0111};
    tbl[16] = '{4'b0111, 7'h19, 8, 1, 0, 1'b0, 16'h4321, 4'b0000};
    tbl[17] = '{4'b1111, 7'h7F, 4, 0, 0, 1'b0, 16'h4321, 4'b0000};

    // Reset for 3 cycles
    rst = 1'b1; an = 4'b1111; seg = 7'h7F;
    repeat (3) @(negedge clk);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_seen", 32'(digit_seen), 32'h0);
    chk("reset_pulses", {29'd0, frame_valid, frame_err, pattern_err}, 32'h0);
    rst = 1'b0;
    fv_cnt = 0; pe_cnt = 0;
    repeat (2) @(negedge clk);
    chk("post_reset_pulses", 32'(fv_cnt + pe_cnt), 32'h0);

    for (int i = 0; i < 18; i++) begin
      run_step(tbl[i].an, tbl[i].seg, tbl[i].hold);
      chk($sformatf("v%0d_fv", i), 32'(fv_cnt), 32'(tbl[i].fv));
      chk($sformatf("v%0d_pe", i), 32'(pe_cnt), 32'(tbl[i].pe));
      chk($sformatf("v%0d_ferr", i), 32'(ferr_last), 32'(tbl[i].ferr));
      chk($sformatf("v%0d_result", i), 32'(tbl[i].res), 32'(result));
      chk($sformatf("v%0d_seen", i), 32'(digit_seen), 32'(tbl[i].seen));
    end

    // Two anodes low together: counter must stay at 0 throughout
    an = 4'b1100; seg = 7'h79; fv_cnt = 0; pe_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("dual_cnt%0d", k), 32'(dut.settle_cnt), 32'h0);
    end
    chk("dual_seen", 32'(digit_seen), 32'h0);
    chk("dual_pulses", 32'(fv_cnt + pe_cnt), 32'h0);
    run_step(4'b1111, 7'h7F, 4);

    // Pin-to-sample latency: not yet after 4 cycles, captured after 5
    run_step(4'b1110, 7'h79, 4);
    chk("lat_before", 32'(digit_seen), 32'h0);
    run_step(4'b1110, 7'h79, 4);
    chk("lat_after", 32'(digit_seen), 32'h1);
    run_step(4'b1101, 7'h79, 8);
    chk("partial_seen", 32'(digit_seen), 32'h3);

    // Reset mid-frame takes effect immediately and discards captures
    an = 4'b1111; seg = 7'h7F;
    rst = 1'b1;
    #1;
    chk("midrst_seen", 32'(digit_seen), 32'h0);
    chk("midrst_result", 32'(result), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_step(4'b1110, 7'h79, 8);
    chk("r1_seen", 32'(digit_seen), 32'h1);
    chk("r1_fv", 32'(fv_cnt), 32'h0);
    run_step(4'b1101, 7'h79, 8);
    chk("r2_fv", 32'(fv_cnt), 32'h0);
    run_step(4'b1011, 7'h79, 8);
    chk("r3_seen", 32'(digit_seen), 32'h7);
    chk("r3_fv", 32'(fv_cnt), 32'h0);
    run_step(4'b0111, 7'h79, 8);
    chk("r4_fv", 32'(fv_cnt), 32'h1);
    chk("r4_result", 32'(result), 32'h1111);
    chk("r4_ferr", 32'(ferr_last), 32'h0);
    run_step(4'b1111, 7'h7F, 4);
    chk("hold_result", 32'(result), 32'h1111);
    chk("stray_frame_err", 32'(stray), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
